// File: rtl/fan_pkg.sv
// Shared types and helpers for the forwarding adder network.
// Default geometry, fill states and a merge popcount.
package fan_pkg;

    localparam int DEF_LANES = 8;
    localparam int DEF_DW    = 16;
    localparam int DEF_VW    = 3;
    localparam int DEF_CW    = 16;
    localparam int NPAIRS    = DEF_LANES / 2;

    // Widest pair vector the popcount helper handles.
    localparam int MAXP = 32;
    localparam int PCW  = 6;

    typedef logic [DEF_DW-1:0] data_t;
    typedef logic [DEF_VW-1:0] vid_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fill_e;

    function automatic logic [PCW-1:0] popcount(
        input logic [MAXP-1:0] v
    );
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < MAXP; i++) begin
            n = n + {{(PCW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fan_pair_node.sv
// One lane pair of a FAN level: merge b into a on matching IDs.
// Ports: lanes a/b (data, vid, lvld) -> result lanes + merge flag.
module fan_pair_node #(
    parameter int DW = 16,
    parameter int VW = 3
) (
    input  logic [DW-1:0] a_data,
    input  logic [VW-1:0] a_vid,
    input  logic          a_lvld,
    input  logic [DW-1:0] b_data,
    input  logic [VW-1:0] b_vid,
    input  logic          b_lvld,
    output logic [DW-1:0] ya_data,
    output logic [VW-1:0] ya_vid,
    output logic          ya_lvld,
    output logic [DW-1:0] yb_data,
    output logic [VW-1:0] yb_vid,
    output logic          yb_lvld,
    output logic          merge
);

    logic          vid_eq;
    logic [DW-1:0] sum;

    vid_cmp #(.W(VW)) u_cmp (
        .a  (a_vid),
        .b  (b_vid),
        .eq (vid_eq)
    );

    ks_adder #(.W(DW)) u_add (
        .a   (a_data),
        .b   (b_data),
        .sum (sum)
    );

    assign merge   = a_lvld & b_lvld & vid_eq;
    assign ya_data = merge ? sum : a_data;
    assign ya_lvld = a_lvld;
    assign yb_data = merge ? '0 : b_data;
    assign yb_lvld = b_lvld & ~merge;
    assign ya_vid  = a_vid;
    assign yb_vid  = b_vid;

endmodule

// File: rtl/ks_adder.sv
// Kogge-Stone prefix adder, modulo 2^W (no carry out).
// Ports: a, b (W bits) -> sum (W bits). W >= 2.
module ks_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    localparam int LV = $clog2(W);

    logic [W-1:0] hp;
    logic [W-2:0] g;
    logic [W-2:0] p;
    logic [W-2:0] gn;
    logic [W-2:0] pn;

    // Prefix tree over the low W-1 bits only: the carry out
    // of the top bit is discarded, so it is never built.
    always_comb begin
        hp = a ^ b;
        g  = a[W-2:0] & b[W-2:0];
        p  = hp[W-2:0];
        gn = '0;
        pn = '0;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < W - 1; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
                    pn[i] = p[i] & p[i-(1<<l)];
                end
            end
            g = gn;
            p = pn;
        end
        sum = hp ^ {g, 1'b0};
    end

endmodule

// File: rtl/vid_cmp.sv
// Vector ID comparator.
// Ports: a, b (W bits) -> eq.
module vid_cmp #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    assign eq = (a == b);

endmodule

// File: rtl/fan_pair_stage.sv
// One registered FAN level with a main+skid output buffer.
// Ports: in_* beat (valid/ready), out_* beat, merge_cnt/cnt_clr.
module fan_pair_stage #(
    parameter int LANES = fan_pkg::DEF_LANES,
    parameter int DW    = fan_pkg::DEF_DW,
    parameter int VW    = fan_pkg::DEF_VW,
    parameter int CW    = fan_pkg::DEF_CW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*DW-1:0] in_data,
    input  logic [LANES*VW-1:0] in_vid,
    input  logic [LANES-1:0]   in_lvld,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic [LANES*VW-1:0] out_vid,
    output logic [LANES-1:0]   out_lvld,
    output logic [CW-1:0]      merge_cnt,
    input  logic               cnt_clr
);

    import fan_pkg::*;

    localparam int NP = LANES / 2;

    logic [LANES*DW-1:0] c_data;
    logic [LANES*VW-1:0] c_vid;
    logic [LANES-1:0]    c_lvld;
    logic [NP-1:0]       merge_vec;

    for (genvar p = 0; p < NP; p++) begin : g_pair
        fan_pair_node #(.DW(DW), .VW(VW)) u_node (
            .a_data  (in_data[(2*p)*DW +: DW]),
            .a_vid   (in_vid[(2*p)*VW +: VW]),
            .a_lvld  (in_lvld[2*p]),
            .b_data  (in_data[(2*p+1)*DW +: DW]),
            .b_vid   (in_vid[(2*p+1)*VW +: VW]),
            .b_lvld  (in_lvld[2*p+1]),
            .ya_data (c_data[(2*p)*DW +: DW]),
            .ya_vid  (c_vid[(2*p)*VW +: VW]),
            .ya_lvld (c_lvld[2*p]),
            .yb_data (c_data[(2*p+1)*DW +: DW]),
            .yb_vid  (c_vid[(2*p+1)*VW +: VW]),
            .yb_lvld (c_lvld[2*p+1]),
            .merge   (merge_vec[p])
        );
    end

    fill_e state_q;
    fill_e state_d;

    logic accept;
    logic drain;
    logic ld_in;
    logic ld_skid;
    logic ld_mv;

    logic [LANES*DW-1:0] skid_data;
    logic [LANES*VW-1:0] skid_vid;
    logic [LANES-1:0]    skid_lvld;

    // Both flags decode the state register, so in_ready
    // never sees out_ready combinationally.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        ld_in   = 1'b0;
        ld_skid = 1'b0;
        ld_mv   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    ld_in   = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    ld_in = 1'b1;
                end else if (accept) begin
                    state_d = TWO;
                    ld_skid = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d = ONE;
                    ld_mv   = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            out_data  <= '0;
            out_vid   <= '0;
            out_lvld  <= '0;
            skid_data <= '0;
            skid_vid  <= '0;
            skid_lvld <= '0;
        end else begin
            state_q <= state_d;
            if (ld_in) begin
                out_data <= c_data;
                out_vid  <= c_vid;
                out_lvld <= c_lvld;
            end else if (ld_mv) begin
                out_data <= skid_data;
                out_vid  <= skid_vid;
                out_lvld <= skid_lvld;
            end
            if (ld_skid) begin
                skid_data <= c_data;
                skid_vid  <= c_vid;
                skid_lvld <= c_lvld;
            end
        end
    end

    logic [MAXP-1:0] merge_ext;
    logic [PCW-1:0]  n_merge;
    logic [CW:0]     cnt_sum;

    assign merge_ext = MAXP'(merge_vec);
    assign n_merge   = popcount(merge_ext);
    assign cnt_sum   = {1'b0, merge_cnt} + (CW+1)'(n_merge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            merge_cnt <= '0;
        end else if (cnt_clr) begin
            merge_cnt <= '0;
        end else if (accept) begin
            merge_cnt <= cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
        end
    end

endmodule

// File: doc/fan_pair_stage.md
Name: fan_pair_stage

Overview:
- One registered level of the forwarding adder network (FAN).
- Takes a beat of LANES product lanes, each carrying a data value, a vector ID and a lane-valid bit.
- Pairs adjacent lanes (2i, 2i+1). If the two vector IDs match and both lanes are valid, it adds them into the even lane and clears the odd lane. Otherwise both lanes pass through unchanged.
- Output is registered behind a valid/ready handshake with a skid entry, so levels can be chained.

Parameters:
- LANES, 8, number of lanes per beat; even and at least 2.
- DW, 16, data width per lane.
- VW, 3, vector ID width per lane.
- CW, 16, width of the merge statistics counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, stage can accept a beat.
- in_data, input, LANES*DW, lane i in bits [i*DW +: DW].
- in_vid, input, LANES*VW, lane i vector ID in bits [i*VW +: VW].
- in_lvld, input, LANES, per-lane valid mask.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, LANES*DW, reduced lane data.
- out_vid, output, LANES*VW, lane vector IDs (passed through).
- out_lvld, output, LANES, lane valid mask after merging.
- merge_cnt, output, CW, saturating count of pair merges performed.
- cnt_clr, input, 1, synchronous clear of merge_cnt.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, merge_cnt=0, skid empty. All data, vid and lvld registers are 0.
- Per-pair function for p = 0..LANES/2-1, where a = lane 2p and b = lane 2p+1:
  - merge = lvld[a] & lvld[b] & (vid[a]==vid[b]).
  - On merge: out lane a data = (data[a]+data[b]) mod 2^DW, with the carry discarded; lvld[a]=1. Out lane b has data=0 and lvld[b]=0. Both output vid fields are copies of the inputs.
  - Otherwise: both lanes are copied unchanged, including lanes with lvld=0 (their data is copied as well).
- Vector IDs are compared by VW-bit equality only.
- Handshake: a transfer occurs on a rising clk edge when valid and ready are both high. No combinational path from out_ready to in_ready.
- Latency: 1 cycle from input acceptance to out_valid when the output is empty or draining.
- Storage is a main output register plus one skid register:
  - in_ready is registered and equals "skid empty".
  - If an input is accepted while the main register holds a beat and out_ready=0, the beat goes to skid and in_ready drops on the next cycle.
  - When the main register drains while skid is full, skid moves to main and in_ready returns to 1.
  - Simultaneous accept and drain with skid empty: the new beat loads main and out_valid stays 1.
- States: EMPTY (out_valid=0), ONE (main full), TWO (main+skid full, in_ready=0).
  - EMPTY to ONE on accept.
  - ONE to EMPTY on drain without accept.
  - ONE to TWO on accept without drain.
  - ONE stays ONE on accept with drain.
  - TWO to ONE on drain.
  - TWO never accepts.
- Order of beats is strictly preserved. No beat is dropped or duplicated.
- merge_cnt:
  - On each accepted input beat, adds the number of merging pairs in that beat.
  - Saturates at 2^CW-1.
  - cnt_clr takes priority: the count becomes 0 that cycle, and merges in the same cycle are not counted.
- Output fields are stable while out_valid=1 and out_ready=0.
- Reset mid-operation discards both held beats immediately.

Decomposition:
- Shared package fan_pkg:
  - lane typedefs: data_t (DW), vid_t (VW).
  - a localparam NPAIRS = LANES/2.
  - a popcount helper function for merge counting.
- Sub-module fan_pair_node (combinational), instantiated NPAIRS times:
  - inputs: two lanes (data, vid, lvld).
  - outputs: two result lanes and a merge flag.
  - vector ID equality inside it uses the team's existing vector ID comparator block.
  - the sum uses the team's Kogge-Stone adder at width DW, with cout ignored.

Test Plan (LANES=4, DW=8, VW=3):
- Merge and pass-through:
  - Stimulus: vid={0,0,1,2}, data={3,5,7,9}, lvld=1111, out_ready=1.
  - Response: next cycle out_data={8,0,7,9}, out_lvld={1,0,1,1}, merge_cnt=1.
- Invalid lane blocks merge:
  - Stimulus: vid={4,4,4,4}, data={1,2,3,4}, lvld={1,0,1,1}.
  - Response: out_data={1,2,7,0}, out_lvld={1,0,1,0}, merge_cnt +1.
- Wrap-around:
  - Stimulus: lanes 0/1 data 200 and 100, same vid.
  - Response: out lane0=44, out lane1 lvld=0.
- Backpressure:
  - Stimulus: out_ready=0, offer beats A,B,C continuously.
  - Response: A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready: outputs A,B,C in order with no gaps after refill.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously in state TWO with merge_cnt=5.
  - Response: immediately out_valid=0, in_ready=1, merge_cnt=0. After release, the next beat has latency 1.
- Counter saturation and clear:
  - Stimulus: CW=4; drive 8 beats of 2 merges each.
  - Response: merge_cnt holds at 15. cnt_clr=1 together with a 2-merge beat gives merge_cnt=0, and the next 2-merge beat gives 2.
